// File: rtl/hs_reg_bridge_if.sv
// Bundles the command/response byte handshakes and the register bus of hs_reg_bridge.
// The master modport is the bridge's view; slave is the UART adapter / register file side.
interface hs_reg_bridge_if;
   logic        cmd_req;
   logic [7:0]  cmd_data;
   logic        cmd_ack;
   logic        rsp_req;
   logic [7:0]  rsp_data;
   logic        rsp_ack;
   logic [15:0] reg_addr;
   logic [15:0] reg_wr_data;
   logic        reg_wr_en;
   logic        reg_rd_en;
   logic [15:0] reg_rd_data;
   logic        reg_rd_ack;

   modport master (
      input  cmd_req, cmd_data, rsp_ack, reg_rd_data, reg_rd_ack,
      output cmd_ack, rsp_req, rsp_data, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
   );

   modport slave (
      output cmd_req, cmd_data, rsp_ack, reg_rd_data, reg_rd_ack,
      input  cmd_ack, rsp_req, rsp_data, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en
   );
endinterface

// File: rtl/hs_reg_bridge.sv
// Byte-frame to register-bus bridge: decodes 'W'/'R' frames from a 4-phase byte handshake,
// issues single-cycle register strobes and returns 1- or 2-byte responses.
module hs_reg_bridge #(
   parameter int unsigned P_BYTE_TIMEOUT = 12_500_000,
   parameter int unsigned P_BUS_TIMEOUT  = 255
) (
   input logic           clk,
   input logic           rst,
   hs_reg_bridge_if.master bus
);

   localparam int unsigned BtW  = $clog2(P_BYTE_TIMEOUT + 1);
   localparam int unsigned BusW = $clog2(P_BUS_TIMEOUT + 1);

   typedef enum logic [3:0] {
      StCmd, StAdrH, StAdrL, StDatH, StDatL, StBusWr, StBusRd, StTx, StTxWait
   } state_e;

   state_e          state_q, state_d;
   logic            cmd_ack_q, cmd_ack_d;
   logic            is_wr_q, is_wr_d;
   logic [7:0]      addr_hi_q, addr_hi_d;
   logic [7:0]      addr_lo_q, addr_lo_d;
   logic [7:0]      data_hi_q, data_hi_d;
   logic [15:0]     reg_addr_q, reg_addr_d;
   logic [15:0]     reg_wr_data_q, reg_wr_data_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic [7:0]      rsp_next_q, rsp_next_d;
   logic            rsp_more_q, rsp_more_d;
   logic            rsp_req_q, rsp_req_d;
   logic            rd_pend_q, rd_pend_d;
   logic [BtW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [BusW-1:0] bus_cnt_q, bus_cnt_d;

   logic byte_state, byte_wait, take, byte_tmo, wr_en, rd_en;

   // Bytes are only accepted in the decode states; elsewhere the adapter is stalled.
   assign byte_state = (state_q == StCmd) || byte_wait;
   assign byte_wait  = (state_q == StAdrH) || (state_q == StAdrL) ||
                       (state_q == StDatH) || (state_q == StDatL);
   assign take       = bus.cmd_req && !cmd_ack_q && byte_state;
   assign byte_tmo   = (byte_cnt_q == BtW'(P_BYTE_TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      cmd_ack_d     = cmd_ack_q;
      is_wr_d       = is_wr_q;
      addr_hi_d     = addr_hi_q;
      addr_lo_d     = addr_lo_q;
      data_hi_d     = data_hi_q;
      reg_addr_d    = reg_addr_q;
      reg_wr_data_d = reg_wr_data_q;
      rsp_data_d    = rsp_data_q;
      rsp_next_d    = rsp_next_q;
      rsp_more_d    = rsp_more_q;
      rsp_req_d     = rsp_req_q;
      rd_pend_d     = rd_pend_q;
      byte_cnt_d    = '0;
      bus_cnt_d     = bus_cnt_q;
      wr_en         = 1'b0;
      rd_en         = 1'b0;

      if (take) begin
         cmd_ack_d = 1'b1;
      end else if (cmd_ack_q && !bus.cmd_req) begin
         cmd_ack_d = 1'b0;
      end

      unique case (state_q)
         StCmd: begin
            if (take) begin
               if (bus.cmd_data == 8'h57 || bus.cmd_data == 8'h52) begin
                  is_wr_d = (bus.cmd_data == 8'h57);
                  state_d = StAdrH;
               end else begin
                  rsp_data_d = 8'h45;
                  rsp_more_d = 1'b0;
                  state_d    = StTx;
               end
            end
         end
         StAdrH: begin
            if (take) begin
               addr_hi_d = bus.cmd_data;
               state_d   = StAdrL;
            end
         end
         StAdrL: begin
            if (take) begin
               if (is_wr_q) begin
                  addr_lo_d = bus.cmd_data;
                  state_d   = StDatH;
               end else begin
                  reg_addr_d = {addr_hi_q, bus.cmd_data};
                  rd_pend_d  = 1'b0;
                  bus_cnt_d  = '0;
                  state_d    = StBusRd;
               end
            end
         end
         StDatH: begin
            if (take) begin
               data_hi_d = bus.cmd_data;
               state_d   = StDatL;
            end
         end
         StDatL: begin
            // Bus-facing address/data only change once a frame is complete.
            if (take) begin
               reg_addr_d    = {addr_hi_q, addr_lo_q};
               reg_wr_data_d = {data_hi_q, bus.cmd_data};
               state_d       = StBusWr;
            end
         end
         StBusWr: begin
            wr_en      = 1'b1;
            rsp_data_d = 8'h4B;
            rsp_more_d = 1'b0;
            state_d    = StTx;
         end
         StBusRd: begin
            rd_en     = !rd_pend_q;
            rd_pend_d = 1'b1;
            if (bus.reg_rd_ack) begin
               rsp_data_d = bus.reg_rd_data[15:8];
               rsp_next_d = bus.reg_rd_data[7:0];
               rsp_more_d = 1'b1;
               state_d    = StTx;
            end else if (bus_cnt_q == BusW'(P_BUS_TIMEOUT)) begin
               rsp_data_d = 8'hDE;
               rsp_next_d = 8'hAD;
               rsp_more_d = 1'b1;
               state_d    = StTx;
            end else begin
               bus_cnt_d = bus_cnt_q + 1'b1;
            end
         end
         StTx: begin
            rsp_req_d = 1'b1;
            state_d   = StTxWait;
         end
         StTxWait: begin
            if (bus.rsp_ack) begin
               rsp_req_d = 1'b0;
               if (rsp_more_q) begin
                  rsp_data_d = rsp_next_q;
                  rsp_more_d = 1'b0;
                  state_d    = StTx;
               end else begin
                  state_d = StCmd;
               end
            end
         end
         default: state_d = StCmd;
      endcase

      // Abandon a stalled frame silently; the ack logic above still finishes its handshake.
      if (byte_wait && !take) begin
         if (byte_tmo) begin
            state_d = StCmd;
         end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StCmd;
         cmd_ack_q     <= 1'b0;
         is_wr_q       <= 1'b0;
         addr_hi_q     <= '0;
         addr_lo_q     <= '0;
         data_hi_q     <= '0;
         reg_addr_q    <= '0;
         reg_wr_data_q <= '0;
         rsp_data_q    <= '0;
         rsp_next_q    <= '0;
         rsp_more_q    <= 1'b0;
         rsp_req_q     <= 1'b0;
         rd_pend_q     <= 1'b0;
         byte_cnt_q    <= '0;
         bus_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ack_q     <= cmd_ack_d;
         is_wr_q       <= is_wr_d;
         addr_hi_q     <= addr_hi_d;
         addr_lo_q     <= addr_lo_d;
         data_hi_q     <= data_hi_d;
         reg_addr_q    <= reg_addr_d;
         reg_wr_data_q <= reg_wr_data_d;
         rsp_data_q    <= rsp_data_d;
         rsp_next_q    <= rsp_next_d;
         rsp_more_q    <= rsp_more_d;
         rsp_req_q     <= rsp_req_d;
         rd_pend_q     <= rd_pend_d;
         byte_cnt_q    <= byte_cnt_d;
         bus_cnt_q     <= bus_cnt_d;
      end
   end

   assign bus.cmd_ack     = cmd_ack_q;
   assign bus.rsp_req     = rsp_req_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.reg_addr    = reg_addr_q;
   assign bus.reg_wr_data = reg_wr_data_q;
   // Strobes decode from state, so mask them while reset is being applied.
   assign bus.reg_wr_en   = wr_en && !rst;
   assign bus.reg_rd_en   = rd_en && !rst;

endmodule

// File: tb/tb_hs_reg_bridge.sv
// Directed bench for hs_reg_bridge: adapter, UART-tx and register-file models with
// scoreboard queues for expected register strobes and response bytes.
module tb_hs_reg_bridge;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hs_reg_bridge_if ifc ();

   hs_reg_bridge #(
      .P_BYTE_TIMEOUT(100),
      .P_BUS_TIMEOUT (255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   int checks = 0, failures = 0;
   logic [7:0]  rsp_q[$];
   logic [31:0] wr_q[$];
   logic [15:0] rd_q[$];
   int rsp_rises = 0, wr_pulses = 0, rd_pulses = 0, ack_rises = 0;
   int exp_rsp = 0, exp_wr = 0, exp_rd = 0, bytes_sent = 0;
   bit hold_ack = 1'b0;
   int rd_delay = 3;
   logic [15:0] rd_val = 16'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_rsp(input logic [7:0] b);
      rsp_q.push_back(b);
      exp_rsp++;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
      wr_q.push_back({a, d});
      exp_wr++;
   endtask

   task automatic push_rd(input logic [15:0] a);
      rd_q.push_back(a);
      exp_rd++;
   endtask

   task automatic wait_ack(input logic lvl, input string tag);
      int n = 0;
      while (ifc.cmd_ack !== lvl && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'h0, ifc.cmd_ack}, {31'h0, lvl});
   endtask

   task automatic send_byte(input logic [7:0] b);
      wait_ack(1'b0, "ack_idle");
      ifc.cmd_req  = 1'b1;
      ifc.cmd_data = b;
      wait_ack(1'b1, "ack_high");
      ifc.cmd_req = 1'b0;
      wait_ack(1'b0, "ack_low");
      bytes_sent++;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((rsp_q.size() != 0 || ifc.rsp_req) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, rsp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor: scoreboard pops and protocol properties, sampled on the falling edge.
   logic        rsp_req_p = 1'b0, wr_p = 1'b0, rd_p = 1'b0, ack_p = 1'b0;
   logic [7:0]  rsp_hold = 8'h0;
   logic [31:0] wr_e;
   logic [15:0] rd_e;
   logic [7:0]  rsp_e;
   always @(negedge clk) begin
      if (ifc.rsp_req && !rsp_req_p) begin
         rsp_rises++;
         rsp_hold = ifc.rsp_data;
         if (rsp_q.size() == 0) begin
            chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
         end else begin
            rsp_e = rsp_q.pop_front();
            chk("rsp_byte", {24'h0, ifc.rsp_data}, {24'h0, rsp_e});
         end
      end else if (ifc.rsp_req && rsp_req_p) begin
         chk("rsp_stable", {24'h0, ifc.rsp_data}, {24'h0, rsp_hold});
      end
      if (ifc.reg_wr_en) begin
         wr_pulses++;
         chk("wr_excl", {31'h0, ifc.reg_rd_en}, 32'd0);
         chk("wr_width", {31'h0, wr_p}, 32'd0);
         if (wr_q.size() == 0) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
         end else begin
            wr_e = wr_q.pop_front();
            chk("wr_addr", {16'h0, ifc.reg_addr}, {16'h0, wr_e[31:16]});
            chk("wr_data", {16'h0, ifc.reg_wr_data}, {16'h0, wr_e[15:0]});
         end
      end
      if (ifc.reg_rd_en) begin
         rd_pulses++;
         chk("rd_width", {31'h0, rd_p}, 32'd0);
         if (rd_q.size() == 0) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
         end else begin
            rd_e = rd_q.pop_front();
            chk("rd_addr", {16'h0, ifc.reg_addr}, {16'h0, rd_e});
         end
      end
      if (ifc.cmd_ack && !ack_p) ack_rises++;
      rsp_req_p = ifc.rsp_req;
      wr_p      = ifc.reg_wr_en;
      rd_p      = ifc.reg_rd_en;
      ack_p     = ifc.cmd_ack;
   end

   // UART transmitter model: a one-cycle rsp_ack a few cycles after rsp_req rises.
   initial begin
      ifc.rsp_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.rsp_req && !hold_ack) begin
            repeat (2) @(negedge clk);
            if (ifc.rsp_req && !hold_ack) begin
               ifc.rsp_ack = 1'b1;
               @(negedge clk);
               ifc.rsp_ack = 1'b0;
               @(negedge clk);
            end
         end
      end
   end

   // Register file model: acks a read rd_delay cycles after the strobe (0 = same cycle).
   initial begin
      ifc.reg_rd_ack  = 1'b0;
      ifc.reg_rd_data = 16'h0;
      forever begin
         @(negedge clk);
         if (ifc.reg_rd_en) begin
            repeat (rd_delay) @(negedge clk);
            ifc.reg_rd_ack  = 1'b1;
            ifc.reg_rd_data = rd_val;
            @(negedge clk);
            ifc.reg_rd_ack = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      ifc.cmd_req  = 1'b0;
      ifc.cmd_data = 8'h0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ack", {31'h0, ifc.cmd_ack}, 32'd0);
      chk("rst_rsp_req", {31'h0, ifc.rsp_req}, 32'd0);
      chk("rst_rsp_data", {24'h0, ifc.rsp_data}, 32'd0);
      chk("rst_reg_addr", {16'h0, ifc.reg_addr}, 32'd0);
      chk("rst_reg_wdata", {16'h0, ifc.reg_wr_data}, 32'd0);
      chk("rst_wr_en", {31'h0, ifc.reg_wr_en}, 32'd0);
      chk("rst_rd_en", {31'h0, ifc.reg_rd_en}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Write frame.
      push_wr(16'h1234, 16'hABCD);
      push_rsp(8'h4B);
      send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      drain("drain_write");
      chk("hold_addr", {16'h0, ifc.reg_addr}, 32'h1234);
      chk("hold_wdata", {16'h0, ifc.reg_wr_data}, 32'hABCD);

      // Read frame, ack 3 cycles after the strobe.
      rd_delay = 3; rd_val = 16'hBEEF;
      push_rd(16'h0010);
      push_rsp(8'hBE); push_rsp(8'hEF);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
      drain("drain_read");

      // Read frame, ack in the same cycle as the strobe.
      rd_delay = 0; rd_val = 16'h5AC3;
      push_rd(16'h0020);
      push_rsp(8'h5A); push_rsp(8'hC3);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
      drain("drain_read_fast");

      // Read with no timely ack; the late ack must be ignored.
      rd_delay = 300; rd_val = 16'h1111;
      push_rd(16'h0010);
      push_rsp(8'hDE); push_rsp(8'hAD);
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
      drain("drain_timeout");
      repeat (100) @(negedge clk);
      chk("late_ack_rsp_req", {31'h0, ifc.rsp_req}, 32'd0);
      chk("late_ack_rsp_count", rsp_rises, exp_rsp);

      // Unknown command, then a normal write.
      push_rsp(8'h45);
      send_byte(8'h00);
      drain("drain_err");
      push_wr(16'h0001, 16'h0002);
      push_rsp(8'h4B);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
      drain("drain_write2");

      // Stalled frame is dropped after the inter-byte timeout.
      send_byte(8'h57); send_byte(8'h12);
      repeat (150) @(negedge clk);
      chk("tmo_wr_count", wr_pulses, exp_wr);
      chk("tmo_rd_count", rd_pulses, exp_rd);
      chk("tmo_rsp_count", rsp_rises, exp_rsp);
      chk("tmo_addr_hold", {16'h0, ifc.reg_addr}, 32'h0001);
      push_wr(16'h0005, 16'h1234);
      push_rsp(8'h4B);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'h12); send_byte(8'h34);
      drain("drain_after_tmo");

      // Reset while waiting for rsp_ack of a read, with the next byte already offered.
      rd_delay = 3; rd_val = 16'h1234;
      push_rd(16'h0030);
      push_rsp(8'h12);
      hold_ack = 1'b1;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h30);
      begin
         int n = 0;
         while (!ifc.rsp_req && n < 500) begin
            @(negedge clk);
            n++;
         end
      end
      chk("txwait_reached", {31'h0, ifc.rsp_req}, 32'd1);
      ifc.cmd_req  = 1'b1;
      ifc.cmd_data = 8'h52;
      repeat (5) @(negedge clk);
      chk("busy_no_ack", {31'h0, ifc.cmd_ack}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_rsp_req", {31'h0, ifc.rsp_req}, 32'd0);
      chk("rst_mid_rsp_data", {24'h0, ifc.rsp_data}, 32'd0);
      chk("rst_mid_addr", {16'h0, ifc.reg_addr}, 32'd0);
      chk("rst_mid_cmd_ack", {31'h0, ifc.cmd_ack}, 32'd0);
      rst      = 1'b0;
      hold_ack = 1'b0;
      wait_ack(1'b1, "post_rst_ack_high");
      ifc.cmd_req = 1'b0;
      wait_ack(1'b0, "post_rst_ack_low");
      bytes_sent++;
      rd_val = 16'hCAFE;
      push_rd(16'h0031);
      push_rsp(8'hCA); push_rsp(8'hFE);
      send_byte(8'h00); send_byte(8'h31);
      drain("drain_post_rst");

      repeat (5) @(negedge clk);
      chk("ack_per_byte", ack_rises, bytes_sent);
      chk("total_wr", wr_pulses, exp_wr);
      chk("total_rd", rd_pulses, exp_rd);
      chk("total_rsp", rsp_rises, exp_rsp);
      chk("wr_queue_empty", wr_q.size(), 0);
      chk("rd_queue_empty", rd_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hs_reg_bridge.md
HS_REG_BRIDGE -- requirements
Module: hs_reg_bridge

Interface
REQ-001 Parameter P_BYTE_TIMEOUT, default 12_500_000, clk cycles allowed between bytes of one frame before the frame is discarded.
REQ-002 Parameter P_BUS_TIMEOUT, default 255, clk cycles allowed for reg_rd_ack after reg_rd_en.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_req  input  1  byte available from the UART adapter.
REQ-006 cmd_data  input  8  byte from the UART adapter, valid while cmd_req high.
REQ-007 cmd_ack  output  1  byte consumed acknowledge.
REQ-008 rsp_req  output  1  request to transmit rsp_data; the adapter starts on the rising edge.
REQ-009 rsp_data  output  8  byte to transmit.
REQ-010 rsp_ack  input  1  single-cycle pulse when the byte has been fully serialized.
REQ-011 reg_addr  output  16  register address.
REQ-012 reg_wr_data  output  16  register write data.
REQ-013 reg_wr_en  output  1  single-cycle write strobe.
REQ-014 reg_rd_en  output  1  single-cycle read strobe.
REQ-015 reg_rd_data  input  16  read data, sampled when reg_rd_ack high.
REQ-016 reg_rd_ack  input  1  read data valid pulse.

Function
REQ-017 The block SHALL consume bytes with a 4-phase handshake: when cmd_req=1 and cmd_ack=0, latch cmd_data and set cmd_ack=1 the next cycle; hold cmd_ack=1 until cmd_req=0 is sampled, then clear it.
REQ-018 The block SHALL accept a new byte only after cmd_ack has returned to 0.
REQ-019 Frames: write = 0x57, ADRH, ADRL, DATH, DATL; read = 0x52, ADRH, ADRL; multi-byte fields are MSB first.
REQ-020 The FSM states SHALL be CMD, ADRH, ADRL, DATH, DATL, BUS_WR, BUS_RD, TX, TX_WAIT.
REQ-021 CMD: 0x57 or 0x52 goes to ADRH; any other byte loads the response 0x45 ('E', 1 byte) and goes to TX.
REQ-022 ADRH->ADRL->(write: DATH->DATL->BUS_WR | read: BUS_RD); each transition happens on byte latch.
REQ-023 BUS_WR: pulse reg_wr_en for 1 cycle with reg_addr/reg_wr_data stable; load the response 0x4B ('K', 1 byte); go to TX.
REQ-024 BUS_RD: pulse reg_rd_en for 1 cycle, then wait for reg_rd_ack; on ack load the response {data[15:8], data[7:0]} (2 bytes).
REQ-025 If reg_rd_ack=1 in the same cycle as reg_rd_en, the block SHALL accept it.
REQ-026 If no ack arrives within P_BUS_TIMEOUT cycles after reg_rd_en, the block SHALL load the response 0xDE, 0xAD and ignore any later reg_rd_ack.
REQ-027 TX: drive rsp_data, then set rsp_req=1 one cycle after rsp_data is valid; go to TX_WAIT.
REQ-028 TX_WAIT: hold rsp_req=1 and rsp_data stable until the rsp_ack pulse, then drive rsp_req=0 for at least 1 cycle.
REQ-029 After TX_WAIT, the block SHALL go to TX if response bytes remain, else to CMD.
REQ-030 reg_addr and reg_wr_data SHALL hold their last value between frames.
REQ-031 An inter-byte counter SHALL run in ADRH, ADRL and DATH/DATL while waiting for a byte.
REQ-032 On reaching P_BYTE_TIMEOUT, the block SHALL return to CMD without any bus strobe or response; a cmd handshake already in progress is still completed.
REQ-033 Bytes arriving during BUS_*, TX or TX_WAIT SHALL NOT be acknowledged until the block is back in CMD; the adapter's flow control absorbs them.
REQ-034 reg_wr_en and reg_rd_en SHALL never be high together and SHALL be at most 1 cycle wide each.

Reset
REQ-035 rst=1 SHALL force the CMD state and set cmd_ack=0, rsp_req=0, rsp_data=0, reg_wr_en=0, reg_rd_en=0, reg_addr=0, reg_wr_data=0, and clear the counters; this applies mid-frame and mid-transmit with no partial strobe.
REQ-036 The first handshake after rst deasserts SHALL be serviced normally.

Verification
REQ-037 Bytes 57 12 34 AB CD -> one reg_wr_en pulse with addr=0x1234, wdata=0xABCD, then response byte 0x4B with a single rsp_req rising edge.
REQ-038 Bytes 52 00 10, reg_rd_ack 3 cycles later with 0xBEEF -> responses 0xBE then 0xEF, rsp_req low for at least 1 cycle between them.
REQ-039 Bytes 52 00 10 with no ack -> after 255 cycles, responses 0xDE, 0xAD; a late ack has no effect.
REQ-040 Byte 0x00 -> response 0x45; next frame 57 00 01 00 02 -> write addr=1, data=2.
REQ-041 Bytes 57 12, then idle longer than P_BYTE_TIMEOUT (reduced to 100 in the bench) -> no strobe; next frame decodes from CMD.
REQ-042 rst asserted in TX_WAIT of a read -> rsp_req=0 next cycle and the state is CMD; cmd_req held high throughout -> cmd_ack toggles exactly once per byte.
